// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU serial command receiver.
// Optional feature macro: ALSU_CMD_RX_PARITY_EN (adds the even-parity bit to the frame).
package alsu_pkg;

  localparam int unsigned FRAME_PAYLOAD_W = 16;

  // Payload field map, LSB first on the wire.
  localparam int unsigned A_LSB         = 0;
  localparam int unsigned A_W           = 3;
  localparam int unsigned B_LSB         = 3;
  localparam int unsigned B_W           = 3;
  localparam int unsigned OPCODE_LSB    = 6;
  localparam int unsigned OPCODE_W      = 3;
  localparam int unsigned CIN_LSB       = 9;
  localparam int unsigned SERIAL_LSB    = 10;
  localparam int unsigned DIRECTION_LSB = 11;
  localparam int unsigned OP_A_LSB      = 12;
  localparam int unsigned OP_B_LSB      = 13;
  localparam int unsigned BYPASS_A_LSB  = 14;
  localparam int unsigned BYPASS_B_LSB  = 15;

  // Packed so that field a lands on payload bits [2:0].
  typedef struct packed {
    logic                bypass_b;
    logic                bypass_a;
    logic                op_b;
    logic                op_a;
    logic                direction;
    logic                serial;
    logic                cin;
    logic [OPCODE_W-1:0] opcode;
    logic [B_W-1:0]      b;
    logic [A_W-1:0]      a;
  } alsu_cmd_t;

`ifdef ALSU_CMD_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_t;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} rx_state_t;
`endif

endpackage

// File: rtl/alsu_cmd_rx_if.sv
// Command handshake bundle between the serial receiver and the ALSU operand/control inputs.
interface alsu_cmd_rx_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] A;
  logic [2:0] B;
  logic [2:0] opcode;
  logic       cin;
  logic       serial;
  logic       direction;
  logic       op_A;
  logic       op_B;
  logic       bypass_A;
  logic       bypass_B;

  // Receiver side: produces the command, observes ready.
  modport master (
    output cmd_valid, A, B, opcode, cin, serial, direction, op_A, op_B, bypass_A, bypass_B,
    input  cmd_ready
  );

  // Consumer side.
  modport slave (
    input  cmd_valid, A, B, opcode, cin, serial, direction, op_A, op_B, bypass_A, bypass_B,
    output cmd_ready
  );

endinterface

// File: rtl/alsu_rx_sync.sv
// Serial line synchroniser with falling-edge detect.
// Flops reset low so a line that is already low at reset release never looks like a start.
module alsu_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchroniser and keep one cycle of history.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign fall_pulse = prev_q & ~rx_s;

endmodule

// File: rtl/alsu_cmd_rx.sv
// Serial command receiver feeding the ALSU operand/control inputs.
// Frame: start(0), 16 payload bits LSB first, [even parity], stop(1).
// Optional feature macro: ALSU_CMD_RX_PARITY_EN (parity bit present, parity_err live).
// CLKS_PER_BIT must be even and >= 4; SYNC_STAGES must be >= 2.
module alsu_cmd_rx
  import alsu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx_in,
  alsu_cmd_rx_if.master      cmd,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(FRAME_PAYLOAD_W);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_PAYLOAD_W - 1);

  logic rx_s;
  logic fall_pulse;

  alsu_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .rx_in      (rx_in),
    .rx_s       (rx_s),
    .fall_pulse (fall_pulse)
  );

  rx_state_t                  state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [IDX_W-1:0]           idx_q;
  logic [FRAME_PAYLOAD_W-1:0] shreg_q;
  alsu_cmd_t                  cmd_q;
  logic                       valid_q;
  logic                       ferr_q;
  logic                       ovr_q;
`ifdef ALSU_CMD_RX_PARITY_EN
  logic                       par_q;
  logic                       perr_q;
`endif

  logic sample;
  assign sample = (cnt_q == '0);

  // Receive FSM, bit timing, payload shift and output handshake.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef ALSU_CMD_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef ALSU_CMD_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // Consumption; a load later in this block overrides it.
      if (valid_q && cmd.cmd_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (fall_pulse) begin
            state_q <= StStart;
            cnt_q   <= HALF_LOAD;
          end
        end

        StStart: begin
          if (sample) begin
            cnt_q <= FULL_LOAD;
            if (!rx_s) begin
              state_q <= StData;
              idx_q   <= '0;
`ifdef ALSU_CMD_RX_PARITY_EN
              par_q   <= 1'b0;
`endif
            end else begin
              state_q <= StIdle;  // glitch, silently ignored
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StData: begin
          if (sample) begin
            cnt_q   <= FULL_LOAD;
            shreg_q <= {rx_s, shreg_q[FRAME_PAYLOAD_W-1:1]};
            idx_q   <= idx_q + 1'b1;
`ifdef ALSU_CMD_RX_PARITY_EN
            par_q   <= par_q ^ rx_s;
            if (idx_q == LAST_IDX) state_q <= StParity;
`else
            if (idx_q == LAST_IDX) state_q <= StStop;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

`ifdef ALSU_CMD_RX_PARITY_EN
        StParity: begin
          if (sample) begin
            cnt_q   <= FULL_LOAD;
            par_q   <= par_q ^ rx_s;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif

        StStop: begin
          if (sample) begin
            cnt_q   <= FULL_LOAD;
            state_q <= StIdle;
            // Framing error takes priority over parity error.
            if (!rx_s) begin
              ferr_q <= 1'b1;
`ifdef ALSU_CMD_RX_PARITY_EN
            end else if (par_q) begin
              perr_q <= 1'b1;
`endif
            end else if (!valid_q || cmd.cmd_ready) begin
              cmd_q   <= alsu_cmd_t'(shreg_q);
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALSU_CMD_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

  assign cmd.cmd_valid = valid_q;
  assign cmd.A         = cmd_q.a;
  assign cmd.B         = cmd_q.b;
  assign cmd.opcode    = cmd_q.opcode;
  assign cmd.cin       = cmd_q.cin;
  assign cmd.serial    = cmd_q.serial;
  assign cmd.direction = cmd_q.direction;
  assign cmd.op_A      = cmd_q.op_a;
  assign cmd.op_B      = cmd_q.op_b;
  assign cmd.bypass_A  = cmd_q.bypass_a;
  assign cmd.bypass_B  = cmd_q.bypass_b;

endmodule

// File: tb/tb_alsu_cmd_rx.sv
// Bench for alsu_cmd_rx: table of back-to-back frames plus hand-written corner sequences.
module tb_alsu_cmd_rx;

  localparam int C = 16;
  localparam int S = 2;
`ifdef ALSU_CMD_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int STOP_IDX = 17 + PAR_EN;
  // Negedge index (counted from driving the start bit) at which cmd_valid is first seen high.
  localparam int LOAD_K = S + C / 2 + STOP_IDX * C + 1;
  localparam int RUN_K  = (STOP_IDX + 1) * C + 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic rx_in = 1'b1;
  logic parity_err, frame_err, overrun, busy;

  alsu_cmd_rx_if cmd_if ();

  alsu_cmd_rx #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (S)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_in      (rx_in),
    .cmd        (cmd_if),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_cmd();
    return {cmd_if.bypass_B, cmd_if.bypass_A, cmd_if.op_B, cmd_if.op_A, cmd_if.direction,
            cmd_if.serial, cmd_if.cin, cmd_if.opcode, cmd_if.B, cmd_if.A};
  endfunction

  function automatic logic [19:0] all_outs();
    return {cmd_if.cmd_valid, dut_cmd(), parity_err, frame_err, overrun, busy};
  endfunction

  function automatic logic frame_bit(input logic [15:0] pl, input logic par, input logic stp,
                                     input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 16) return pl[idx-1];
    if (idx == STOP_IDX) return stp;
    return par;
  endfunction

  // Drives one frame and counts what the DUT does while it is on the wire.
  task automatic run_frame(input logic [15:0] pl, input logic par, input logic stp,
                           input int ready_at, input logic idle_lvl,
                           output int rise, output int n_perr, output int n_ferr,
                           output int n_ovr);
    logic prev_v;
    rise   = -1;
    n_perr = 0;
    n_ferr = 0;
    n_ovr  = 0;
    prev_v = 1'b0;
    for (int k = 0; k < RUN_K; k++) begin
      @(negedge clk);
      if (k > 0 && cmd_if.cmd_valid && !prev_v && rise < 0) rise = k;
      prev_v = cmd_if.cmd_valid;
      n_perr += int'(parity_err);
      n_ferr += int'(frame_err);
      n_ovr  += int'(overrun);
      rx_in = (k < (STOP_IDX + 1) * C) ? frame_bit(pl, par, stp, k / C) : idle_lvl;
      cmd_if.cmd_ready = (k == ready_at);
    end
  endtask

  typedef struct {
    logic [15:0] pl;
    logic        par;
    logic        stp;
    int          ready_at;
    int          exp_rise;
    logic        exp_valid;
    logic [15:0] exp_cmd;
    int          exp_perr;
    int          exp_ferr;
    int          exp_ovr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rise, np, nf, no, nb, nv;

`ifdef ALSU_CMD_RX_PARITY_EN
    vecs[0] = '{16'h029D, 1'b0, 1'b1, -1,         LOAD_K, 1'b1, 16'h029D, 0, 0, 0};
    vecs[1] = '{16'hC007, 1'b1, 1'b1, -1,         -1,     1'b1, 16'h029D, 0, 0, 1};
    vecs[2] = '{16'hC007, 1'b1, 1'b1, LOAD_K - 1, -1,     1'b1, 16'hC007, 0, 0, 0};
    vecs[3] = '{16'h029D, 1'b1, 1'b1, 100,        -1,     1'b0, 16'h0000, 1, 0, 0};
    vecs[4] = '{16'h029D, 1'b0, 1'b0, -1,         -1,     1'b0, 16'h0000, 0, 1, 0};
    vecs[5] = '{16'h029D, 1'b1, 1'b0, -1,         -1,     1'b0, 16'h0000, 0, 1, 0};
    vecs[6] = '{16'h5555, 1'b0, 1'b1, 50,         LOAD_K, 1'b1, 16'h5555, 0, 0, 0};
    vecs[7] = '{16'hFFFF, 1'b0, 1'b1, -1,         -1,     1'b1, 16'h5555, 0, 0, 1};
    vecs[8] = '{16'h0000, 1'b0, 1'b1, 10,         LOAD_K, 1'b1, 16'h0000, 0, 0, 0};
`else
    vecs[0] = '{16'h029D, 1'b0, 1'b1, -1,         LOAD_K, 1'b1, 16'h029D, 0, 0, 0};
    vecs[1] = '{16'hC007, 1'b1, 1'b1, -1,         -1,     1'b1, 16'h029D, 0, 0, 1};
    vecs[2] = '{16'hC007, 1'b1, 1'b1, LOAD_K - 1, -1,     1'b1, 16'hC007, 0, 0, 0};
    vecs[3] = '{16'h029D, 1'b1, 1'b1, 100,        LOAD_K, 1'b1, 16'h029D, 0, 0, 0};
    vecs[4] = '{16'h029D, 1'b0, 1'b0, -1,         -1,     1'b1, 16'h029D, 0, 1, 0};
    vecs[5] = '{16'h029D, 1'b1, 1'b0, -1,         -1,     1'b1, 16'h029D, 0, 1, 0};
    vecs[6] = '{16'h5555, 1'b0, 1'b1, 50,         LOAD_K, 1'b1, 16'h5555, 0, 0, 0};
    vecs[7] = '{16'hFFFF, 1'b0, 1'b1, -1,         -1,     1'b1, 16'h5555, 0, 0, 1};
    vecs[8] = '{16'h0000, 1'b0, 1'b1, 10,         LOAD_K, 1'b1, 16'h0000, 0, 0, 0};
`endif

    // Reset state, during and after reset.
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_during", int'(all_outs()), 0);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outs_after", int'(all_outs()), 0);

    // Table of consecutive frames; state carries from one vector to the next.
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].pl, vecs[i].par, vecs[i].stp, vecs[i].ready_at, 1'b1, rise, np, nf, no);
      check($sformatf("v%0d_rise_cycle", i), rise, vecs[i].exp_rise);
      check($sformatf("v%0d_valid", i), int'(cmd_if.cmd_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("v%0d_cmd", i), int'(dut_cmd()),
                                   int'(vecs[i].exp_cmd));
      check($sformatf("v%0d_parity_err", i), np, vecs[i].exp_perr);
      check($sformatf("v%0d_frame_err", i), nf, vecs[i].exp_ferr);
      check($sformatf("v%0d_overrun", i), no, vecs[i].exp_ovr);
      check($sformatf("v%0d_busy_end", i), int'(busy), 0);
    end

    // Short low glitch: START rejects it, busy for exactly C/2 cycles, nothing else changes.
    nb = 0;
    np = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nb += int'(busy);
      np += int'(parity_err) + int'(frame_err) + int'(overrun);
      rx_in = (k < 4) ? 1'b0 : 1'b1;
    end
    check("glitch_busy_cycles", nb, C / 2);
    check("glitch_pulses", np, 0);
    check("glitch_valid", int'(cmd_if.cmd_valid), 1);
    check("glitch_cmd", int'(dut_cmd()), 16'h0000);
    check("glitch_busy_end", int'(busy), 0);

    // Drain the held command with a one-cycle ready.
    @(negedge clk);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check("drain_valid", int'(cmd_if.cmd_valid), 0);

    // Bad stop bit, then the line stays low (break): no new frame until it rises and falls.
    run_frame(16'h029D, 1'b0, 1'b0, -1, 1'b0, rise, np, nf, no);
    check("break_frame_err", nf, 1);
    check("break_valid", int'(cmd_if.cmd_valid), 0);
    nb = 0;
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      nb += int'(busy);
      nv += int'(cmd_if.cmd_valid);
    end
    check("break_hold_busy", nb, 0);
    check("break_hold_valid", nv, 0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    run_frame(16'h029D, 1'b0, 1'b1, -1, 1'b1, rise, np, nf, no);
    check("after_break_rise_cycle", rise, LOAD_K);
    check("after_break_A", int'(cmd_if.A), 5);
    check("after_break_B", int'(cmd_if.B), 3);
    check("after_break_opcode", int'(cmd_if.opcode), 2);
    check("after_break_cin", int'(cmd_if.cin), 1);
    check("after_break_errs", np + nf + no, 0);

    // Reset in the middle of the data bits.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rx_in = frame_bit(16'hFFFF, 1'b0, 1'b1, k / C);
    end
    @(negedge clk);
    check("mid_frame_busy", int'(busy), 1);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_reset_outs", int'(all_outs()), 0);
    @(negedge clk);
    rx_in = 1'b1;
    rstn  = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_outs", int'(all_outs()), 0);
    run_frame(16'h029D, 1'b0, 1'b1, -1, 1'b1, rise, np, nf, no);
    check("post_reset_rise_cycle", rise, LOAD_K);
    check("post_reset_cmd", int'(dut_cmd()), 16'h029D);
    check("post_reset_errs", np + nf + no, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
